// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, reset PC and instruction field positions.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPC_MSB    = 31;
    localparam int unsigned OPC_LSB    = 26;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned TARGET_MSB = 25;
    localparam int unsigned TARGET_LSB = 0;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC select: jr > jump > taken branch > sequential.
module fetch_unit_pc_next (
    input  logic [31:0] i_pc_plus4,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    input  logic        i_branch,
    input  logic        i_zero,
    input  logic        i_jump,
    input  logic        i_jr,
    input  logic [29:0] i_jr_target,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_branch_off;

    assign w_branch_off = {{14{i_imm[15]}}, i_imm, 2'b00};

    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jr) begin
            o_next_pc = {i_jr_target, 2'b00};
        end else if (i_jump) begin
            o_next_pc = {i_pc_plus4[31:28], i_target, 2'b00};
        end else if (i_branch && i_zero) begin
            o_next_pc = i_pc_plus4 + w_branch_off;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, instruction register and retired counter.
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             branch,
    input  logic             jump,
    input  logic             zero,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired
);

    state_e           r_state;
    state_e           w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_retired;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_FETCH;
            S_FETCH: w_state_next = imem_ack ? S_EXEC : S_FETCH;
            S_EXEC:  w_state_next = S_FETCH;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Decoded from state so reset drops the request without waiting for an edge.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            S_FETCH: imem_req    = 1'b1;
            S_EXEC:  instr_valid = 1'b1;
            default: ;
        endcase
    end

    fetch_unit_pc_next u_pc_next (
        .i_pc_plus4  (w_pc_plus4),
        .i_imm       (r_instr[IMM_MSB:IMM_LSB]),
        .i_target    (r_instr[TARGET_MSB:TARGET_LSB]),
        .i_branch    (branch),
        .i_zero      (zero),
        .i_jump      (jump),
        .i_jr        (jr),
        .i_jr_target (jr_target[31:2]),
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_retired <= '0;
        end else begin
            if (r_state == S_FETCH && imem_ack) begin
                r_instr <= imem_rdata;
            end
            if (r_state == S_EXEC) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign instr     = r_instr;
    assign retired   = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed and randomized instructions checked against a PC/retire model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;

    // Second instance: wrapping PC and a tiny retired counter.
    logic        rst2 = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] instr2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] pc_plus4_2;
    logic [1:0]  retired2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_pc;
    int unsigned model_ret;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .jr          (jr),
        .jr_target   (jr_target),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retired     (retired)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_wrap (
        .clk         (clk),
        .rst         (rst2),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_ack    (1'b1),
        .imem_rdata  (32'h0000_0000),
        .branch      (1'b0),
        .jump        (1'b0),
        .zero        (1'b0),
        .jr          (1'b0),
        .jr_target   (32'h0000_0000),
        .instr       (instr2),
        .instr_valid (valid2),
        .pc          (pc2),
        .pc_plus4    (pc_plus4_2),
        .retired     (retired2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule, written as plain arithmetic on the fields.
    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] iw,
                                               input logic b, input logic z, input logic j,
                                               input logic r, input logic [31:0] tgt);
        logic [31:0]        p4;
        logic signed [15:0] imm;
        p4  = cur_pc + 32'd4;
        imm = iw[15:0];
        if (r) return tgt & 32'hFFFF_FFFC;
        if (j) return (p4 & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 32'd4);
        if (b && z) return p4 + 32'(int'(imm) * 4);
        return p4;
    endfunction

    // Entered and left at #1 after an edge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] iw, input int waits, input logic b,
                             input logic z, input logic j, input logic r,
                             input logic [31:0] tgt);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, model_pc);
        for (int w = 0; w < waits; w++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            step();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, model_pc);
            chk("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = iw;
        step();
        chk("exec_valid", 32'(instr_valid), 32'd1);
        chk("exec_instr", instr, iw);
        chk("exec_pc", pc, model_pc);
        chk("exec_pc_plus4", pc_plus4, model_pc + 32'd4);
        chk("exec_req", 32'(imem_req), 32'd0);
        // Ack during EXEC must be ignored.
        imem_ack   = 1'($urandom);
        imem_rdata = ~iw;
        branch     = b;
        zero       = z;
        jump       = j;
        jr         = r;
        jr_target  = tgt;
        step();
        model_pc  = model_next(model_pc, iw, b, z, j, r, tgt);
        model_ret = model_ret + 1;
        branch    = 1'b0;
        zero      = 1'b0;
        jump      = 1'b0;
        jr        = 1'b0;
        imem_ack  = 1'b0;
        chk("post_pc", pc, model_pc);
        chk("post_retired", retired, model_ret);
        chk("post_instr_hold", instr, iw);
        chk("post_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        #1;
        rst  = 1'b1;
        rst2 = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("wrap_rst_plus4", pc_plus4_2, 32'h0);
        step();
        rst = 1'b0;
        step();
        model_pc  = 32'h0;
        model_ret = 0;
        chk("first_fetch_addr", imem_addr, 32'h0);

        // Back-to-back addi with immediate ack.
        for (int i = 0; i < 3; i++) run_instr(32'h2008_0005, 0, 0, 0, 0, 0, 32'h0);
        chk("three_retired", retired, 32'd3);
        chk("addr_after_three", imem_addr, 32'hC);

        // Delayed ack; then reach pc=0x10 for the BEQ cases.
        run_instr(32'h2008_0005, 3, 0, 0, 0, 0, 32'h0);
        chk("pc_0x10", pc, 32'h10);
        run_instr(32'h1000_FFFC, 0, 1, 1, 0, 0, 32'h0);
        chk("beq_taken", pc, 32'h4);
        for (int i = 0; i < 3; i++) run_instr(32'h0, 1, 0, 0, 0, 0, 32'h0);
        run_instr(32'h1000_FFFC, 0, 1, 0, 0, 0, 32'h0);
        chk("beq_not_taken", pc, 32'h14);

        run_instr(32'h0, 0, 0, 0, 0, 1, 32'h4000_0000);
        run_instr(32'h0800_0100, 0, 0, 0, 1, 0, 32'h0);
        chk("j_target", pc, 32'h4000_0400);
        run_instr(32'h0800_0100, 2, 1, 1, 1, 1, 32'h0000_1237);
        chk("jr_priority", pc, 32'h1234);

        for (int i = 0; i < 40; i++) begin
            run_instr($urandom, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0), $urandom);
        end

        // Reset in the middle of a FETCH wait.
        imem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midfetch_req", 32'(imem_req), 32'd0);
        chk("midfetch_pc", pc, 32'h0);
        chk("midfetch_instr", instr, 32'h0);
        chk("midfetch_retired", retired, 32'h0);
        step();
        rst = 1'b0;
        step();
        model_pc  = 32'h0;
        model_ret = 0;
        run_instr(32'h2008_0005, 1, 0, 0, 0, 0, 32'h0);

        // Wrapping instance: ack tied high, nop stream.
        rst2 = 1'b0;
        step();
        chk("wrap_fetch_addr", addr2, 32'hFFFF_FFFC);
        chk("wrap_fetch_req", 32'(req2), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("wrap_exec_valid", 32'(valid2), 32'd1);
            step();
            chk("wrap_addr", addr2, 32'hFFFF_FFFC + 32'(4 * k));
            chk("wrap_retired", 32'(retired2), 32'(k % 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Holds the PC and fetches from instruction memory over a req/ack handshake.
- Latches the instruction into an instruction register, whose opcode field drives the decoder.
- Computes the next PC from the decoder's branch/jump outputs, the ALU zero flag and a register jump target (jr).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch byte address; always equals pc.
- imem_ack  in  1  memory has data on imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- branch  in  1  branch request from the decoder.
- jump  in  1  jump request from the decoder.
- zero  in  1  ALU zero flag.
- jr  in  1  jump-register request from the ALU decoder.
- jr_target  in  32  rs value for jr.
- instr  out  32  instruction register; instr[31:26] drives the decoder opcode.
- instr_valid  out  1  instr is executing this cycle.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, used for the jal writeback.
- retired  out  CNT_W  count of executed instructions.

Behaviour:
- Reset (async, immediate): state=S_IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0.
- States:
  - S_IDLE: entered only via reset; moves to S_FETCH on the first clock edge after rst deasserts.
  - S_FETCH: imem_req=1 (decoded from state), imem_addr=pc. When imem_ack=1 at a clock edge: instr<=imem_rdata and go to S_EXEC. Otherwise stay, holding req and addr stable.
  - S_EXEC: instr_valid=1 for exactly one cycle. The decoder and datapath act on instr combinationally, and branch/jump/zero/jr/jr_target are sampled at the closing edge. At that edge pc<=next_pc, retired<=retired+1, then go to S_FETCH.
- Instruction latency: minimum 2 cycles (one FETCH cycle with immediate ack, then one EXEC cycle). Each wait cycle adds one.
- imem_ack is ignored in S_IDLE and S_EXEC. instr holds its value outside the capture edge.
- next_pc priority, highest first:
  - jr: {jr_target[31:2],2'b00}; the low two bits are forced to 0.
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch & zero: pc_plus4 + (sign_extend(instr[15:0]) << 2).
  - otherwise: pc_plus4.
- Simultaneous requests resolve by this priority. branch=1 with zero=0 falls through to pc_plus4.
- All PC arithmetic is modulo 2^32 and silently wraps (e.g. pc=32'hFFFF_FFFC gives pc_plus4=0). retired wraps to 0 at all-ones.
- Control inputs are don't-care outside S_EXEC. X on them in S_EXEC is a bench error.
- Reset mid-fetch: imem_req drops immediately and asynchronously, and the pending ack is abandoned. Reset mid-exec: the PC update is discarded.
- pc_plus4 is combinational from pc and valid in every state.

Decomposition:
- Shared package: state encodings S_IDLE/S_FETCH/S_EXEC (2-bit), RESET_PC default, instruction field position constants (OPC_MSB/LSB, IMM, TARGET).
- One sub-module, pc_next: purely combinational next-PC/priority mux; the top instantiates it and owns the FSM, PC, IR and counter.

Test Plan:
- Reset then release with ack tied high, memory returning 32'h2008_0005 (addi) at 0: imem_addr sequence 0,4,8; instr_valid pulses every 2nd cycle; retired=3 after 6 cycles.
- Ack delayed 3 cycles: imem_req and imem_addr held stable for 4 cycles; instr_valid exactly one cycle; pc unchanged until after EXEC.
- BEQ at pc=0x10, imm=16'hFFFC, branch=1, zero=1 -> next pc=0x04. Same with zero=0 -> 0x14.
- J at pc=0x4000_0000, target field 26'h0000100 -> pc=0x4000_0400. jr=1 with jump=1, jr_target=0x1237 -> pc=0x1234.
- Wrap: RESET_PC=32'hFFFF_FFFC, no control -> pc_plus4=0 and next fetch address 0. Force retired near all-ones -> it wraps to 0.
- rst asserted while in S_FETCH with req high -> req low same cycle, pc=RESET_PC, instr=0. After release, first fetch is from RESET_PC.
